sig_lane_fifo: RTL and testbench
================================

Name: sig_lane_fifo

Overview:
- Parametrised multi-lane valid/ready buffer placed between a producing sub-block and a consuming sub-block at the top level.
- Carries a packed-array payload of NUM_CH lanes, each DW bits wide, plus a per-lane enable mask.
- Successor to the fixed-width, unbuffered direct hookup: it adds depth, back-pressure, lane masking, flush and optional dropping of empty beats.

Parameters:
- DW, 8, width of one lane in bits.
- NUM_CH, 3, number of lanes. Payload is [NUM_CH-1:0][DW-1:0], packed.
- DEPTH, 4, number of entries. Must be a power of two, ≥2.
- AF_LEVEL, 3, almost_full asserts when count ≥ AF_LEVEL. Range 1..DEPTH.
- DROP_ZERO_MASK, 0, when 1, accepted beats with an all-zero mask are discarded rather than stored.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of contents.
- in_valid, in, 1, producer beat valid.
- in_ready, out, 1, buffer can accept a beat.
- in_data, in, NUM_CH*DW, packed [NUM_CH-1:0][DW-1:0] payload.
- in_mask, in, NUM_CH, per-lane enable.
- out_valid, out, 1, head entry valid.
- out_ready, in, 1, consumer accepts the head.
- out_data, out, NUM_CH*DW, head payload with masked lanes forced to 0.
- out_mask, out, NUM_CH, head mask.
- count, out, $clog2(DEPTH)+1, current occupancy.
- almost_full, out, 1, count ≥ AF_LEVEL.
- drop_cnt, out, 8, saturating count of dropped zero-mask beats.

Behaviour:
- Reset: rst_n low asynchronously clears pointers, count, drop_cnt, out_valid, out_data, out_mask, almost_full and in_ready to 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-transfer loses all contents; no beat survives reset.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Storage: circular RAM. Read/write pointers are $clog2(DEPTH) bits and wrap naturally; count tracks occupancy 0..DEPTH.
- All outputs are registered. in_ready, out_valid, almost_full and count depend only on state, never combinationally on in_valid/out_ready.
- in_ready = (count_next < DEPTH), registered.
  - At full, a pop in cycle N raises in_ready in cycle N+1, not N.
  - At full with no pop, in_ready = 0.
- Latency: a beat pushed into an empty FIFO in cycle N shows out_valid = 1 in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop when empty: impossible, since out_valid = 0.
- Head data is stable while out_valid & !out_ready.
- Lane masking: out_data lane i = stored lane i if stored mask[i] = 1, else 0. out_mask = stored mask.
- DROP_ZERO_MASK = 1:
  - A push with in_mask = 0 completes the handshake but is not written.
  - Pointers and count are unchanged; drop_cnt increments, saturating at 255.
- DROP_ZERO_MASK = 0: zero-mask beats are stored normally and drop_cnt stays 0.
- Flush:
  - Has priority over push and pop in the same cycle. A push or pop coinciding with flush is discarded.
  - Next cycle: count = 0, out_valid = 0, almost_full = 0, in_ready = 1.
  - drop_cnt is not cleared by flush.
- almost_full is computed from count_next and registered, so it tracks count in the same cycle.

Test Plan:
1. Reset/latency: hold rst_n = 0 for 3 cycles, release, push {8'h11,8'h22,8'h33} with mask 3'b111 on the first in_ready → out_valid next cycle, out_data = 24'h112233, count = 1.
2. Fill/back-pressure: out_ready = 0, push 5 beats 0x01..0x05 (DEPTH = 4) → first 4 accepted, in_ready = 0 after the 4th, count = 4, almost_full = 1 from count = 3. Pop once → in_ready = 1 the following cycle. Beat 5 is then accepted and drained last, giving order 1,2,3,4,5.
3. Concurrent push/pop + wrap: stream 20 beats with out_ready toggling 1,0,1,1 → every beat emerges in order and count never exceeds 4. Pointers wrap 5 times.
4. Lane mask: push 24'hAABBCC with mask 3'b010 → out_data = 24'h00BB00, out_mask = 3'b010.
5. Drop mode: DROP_ZERO_MASK = 1, push 3 zero-mask beats then 1 valid beat → count = 1, drop_cnt = 3. Push 300 zero-mask beats → drop_cnt = 255.
6. Flush collision: count = 3, assert flush with in_valid = 1 and out_ready = 1 in the same cycle → next cycle count = 0, out_valid = 0, and no beat is seen downstream. Assert rst_n low mid-stream → all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/sig_lane_fifo.sv
// ============================================================================
//  Module      : sig_lane_fifo
//  Description : Multi-lane valid/ready buffer between a producing and a
//                consuming sub-block. Stores NUM_CH lanes of DW bits plus a
//                per-lane enable mask in a circular RAM of DEPTH entries.
//                Offers back-pressure, lane masking on the output, a
//                synchronous flush and optional dropping of zero-mask beats.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1              rising-edge clock
//    rst_n        in   1              asynchronous active-low reset
//    flush        in   1              synchronous clear of contents
//    in_valid     in   1              producer beat valid
//    in_ready     out  1              buffer can accept a beat (registered)
//    in_data      in   NUM_CH*DW      packed [NUM_CH-1:0][DW-1:0] payload
//    in_mask      in   NUM_CH         per-lane enable
//    out_valid    out  1              head entry valid (registered)
//    out_ready    in   1              consumer accepts the head
//    out_data     out  NUM_CH*DW      head payload, disabled lanes zeroed
//    out_mask     out  NUM_CH         head mask
//    count        out  clog2(DEPTH)+1 current occupancy
//    almost_full  out  1              count >= AF_LEVEL
//    drop_cnt     out  8              saturating count of dropped beats
// ============================================================================
`default_nettype none

module sig_lane_fifo #(
    parameter int DW             = 8,
    parameter int NUM_CH         = 3,
    parameter int DEPTH          = 4,
    parameter int AF_LEVEL       = 3,
    parameter int DROP_ZERO_MASK = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH-1:0][DW-1:0]    in_data,
    input  logic [NUM_CH-1:0]            in_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0][DW-1:0]    out_data,
    output logic [NUM_CH-1:0]            out_mask,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full,
    output logic [7:0]                   drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
    localparam logic [7:0]    c_drop_max = 8'hFF;

    // ------------------------------------------------------------------
    // Storage (no reset: contents are meaningless once count is cleared)
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][DW-1:0] mem_data_q [DEPTH];
    logic [NUM_CH-1:0]         mem_mask_q [DEPTH];

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [PW-1:0]             wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q,      rd_ptr_d;
    logic [CW-1:0]             count_q,       count_d;
    logic                      in_ready_q,    in_ready_d;
    logic                      out_valid_q,   out_valid_d;
    logic [NUM_CH-1:0][DW-1:0] out_data_q,    out_data_d;
    logic [NUM_CH-1:0]         out_mask_q,    out_mask_d;
    logic                      almost_full_q, almost_full_d;
    logic [7:0]                drop_cnt_q,    drop_cnt_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_store;
    logic w_pop_eff;

    assign w_push    = in_valid & in_ready_q;
    assign w_pop     = out_valid_q & out_ready;
    // A zero-mask beat completes its handshake but is never written.
    assign w_drop    = (DROP_ZERO_MASK != 0) && (in_mask == '0);
    // Flush wins over both sides of the handshake.
    assign w_store   = w_push & ~w_drop & ~flush;
    assign w_pop_eff = w_pop & ~flush;

    // ------------------------------------------------------------------
    // Head selection for the registered output stage.
    // The output registers are loaded with the entry that will be at the
    // head after this edge. When that entry is being written on this very
    // edge (its slot is wr_ptr_q) it is not yet in the RAM, so take it from
    // the input. A full FIFO also has rd == wr, but then nothing is stored,
    // hence the qualification with w_store.
    // ------------------------------------------------------------------
    logic                      w_head_from_in;
    logic [NUM_CH-1:0][DW-1:0] w_head_data;
    logic [NUM_CH-1:0]         w_head_mask;
    logic [NUM_CH-1:0][DW-1:0] w_head_masked;

    assign w_head_from_in = w_store && (rd_ptr_d == wr_ptr_q);
    assign w_head_data    = w_head_from_in ? in_data : mem_data_q[rd_ptr_d];
    assign w_head_mask    = w_head_from_in ? in_mask : mem_mask_q[rd_ptr_d];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        assign w_head_masked[gi] = w_head_mask[gi] ? w_head_data[gi] : '0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide and wrap naturally at DEPTH.
            if (w_store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop_eff) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(w_store) - CW'(w_pop_eff);
            if (w_push && w_drop && (drop_cnt_q != c_drop_max)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Status flags and head registers are all derived from the post-edge
    // occupancy so that they line up with count in the same cycle.
    always_comb begin
        in_ready_d    = (count_d < c_depth);
        almost_full_d = (count_d >= c_af_level);
        out_valid_d   = (count_d != '0);
        out_data_d    = '0;
        out_mask_d    = '0;
        if (out_valid_d) begin
            out_data_d = w_head_masked;
            out_mask_d = w_head_mask;
        end
    end

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_mask_q[wr_ptr_q] <= in_mask;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_mask_q    <= '0;
            almost_full_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_mask_q    <= out_mask_d;
            almost_full_q <= almost_full_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_mask    = out_mask_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sig_lane_fifo.sv
// ============================================================================
//  Module      : tb_sig_lane_fifo
//  Description : Self-checking bench for sig_lane_fifo. One instance with
//                default parameters (zero-mask beats stored) and one with
//                DROP_ZERO_MASK = 1, sharing clock, reset and stimulus.
//                Directed vectors with hand-computed results plus a small
//                queue model of the default instance's contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sig_lane_fifo;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [2:0][7:0]   in_data;
    logic [2:0]        in_mask;
    logic              out_ready;

    logic              in_ready,    d_in_ready;
    logic              out_valid,   d_out_valid;
    logic [2:0][7:0]   out_data,    d_out_data;
    logic [2:0]        out_mask,    d_out_mask;
    logic [2:0]        count,       d_count;
    logic              almost_full, d_almost_full;
    logic [7:0]        drop_cnt,    d_drop_cnt;

    always #5 clk = ~clk;

    sig_lane_fifo dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mask(out_mask),
        .count(count), .almost_full(almost_full), .drop_cnt(drop_cnt)
    );

    sig_lane_fifo #(.DROP_ZERO_MASK(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(d_out_valid), .out_ready(out_ready),
        .out_data(d_out_data), .out_mask(d_out_mask),
        .count(d_count), .almost_full(d_almost_full), .drop_cnt(d_drop_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;
    int rx_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mask_fn(input logic [23:0] d, input logic [2:0] m);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < 3; i++) begin
            if (!m[i]) r[i*8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [23:0] beat3(input int i);
        return {8'(i + 8'h80), 8'(i + 8'h40), 8'(i + 1)};
    endfunction

    // Reference queue for the default instance, evaluated mid-cycle.
    logic [23:0] q_data[$];
    logic [2:0]  q_mask[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            q_data.delete();
            q_mask.delete();
        end else begin
            chk("count_model", 32'(count), 32'(q_data.size()));
            chk("valid_model", 32'(out_valid), 32'(q_data.size() != 0));
            if (flush) begin
                q_data.delete();
                q_mask.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q_data.size() == 0) begin
                        chk("pop_empty", 32'(out_valid), 32'd0);
                    end else begin
                        chk("head_data", 32'(out_data), 32'(q_data[0]));
                        chk("head_mask", 32'(out_mask), 32'(q_mask[0]));
                        void'(q_data.pop_front());
                        void'(q_mask.pop_front());
                        rx_cnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    q_data.push_back(mask_fn(in_data, in_mask));
                    q_mask.push_back(in_mask);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        logic       acc;
        int         sent;
        int         rx0;
        int         maxc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_mask = '0; out_ready = 1'b0;

        // ---------------- 1: reset and first-beat latency ----------------
        repeat (3) tick();
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_valid",    32'(out_valid),   32'd0);
        chk("rst_ready",    32'(in_ready),    32'd0);
        chk("rst_af",       32'(almost_full), 32'd0);
        chk("rst_data",     32'(out_data),    32'd0);
        chk("rst_drop",     32'(drop_cnt),    32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_low_at_release", 32'(in_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = {8'h11, 8'h22, 8'h33}; in_mask = 3'b111;
        tick();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data),  32'h112233);
        chk("t1_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drained", 32'(count), 32'd0);

        // ---------------- 2: fill and back-pressure ----------------
        in_valid = 1'b1; in_mask = 3'b111; in_data = {3{8'h01}};
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t2_count", 32'(count), 32'(k));
            chk("t2_af",    32'(almost_full), 32'(k >= 3));
            chk("t2_ready", 32'(in_ready),    32'(k < 4));
            in_data = {3{8'(k + 1)}};
        end
        tick();
        chk("t2_full_hold", 32'(count),    32'd4);
        chk("t2_full_rdy",  32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_pop_count", 32'(count),    32'd3);
        chk("t2_pop_rdy",   32'(in_ready), 32'd1);
        chk("t2_head2",     32'(out_data), 32'h020202);
        tick();
        in_valid = 1'b0;
        chk("t2_beat5", 32'(count), 32'd4);
        rx0 = rx_cnt;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t2_drain_count", 32'(count),      32'd0);
        chk("t2_drain_rx",    32'(rx_cnt - rx0), 32'd4);

        // ---------------- 3: streaming with wrap ----------------
        pat = 4'b1101;
        sent = 0; maxc = 0; rx0 = rx_cnt;
        in_valid = 1'b1; in_mask = 3'b111; in_data = beat3(0);
        for (int cyc = 0; cyc < 300 && !(sent == 20 && count == 0); cyc++) begin
            out_ready = pat[cyc % 4];
            acc = in_valid && in_ready;
            tick();
            if (int'(count) > maxc) maxc = int'(count);
            if (acc) begin
                sent++;
                if (sent == 20) in_valid = 1'b0;
                else            in_data  = beat3(sent);
            end
        end
        out_ready = 1'b0;
        chk("t3_sent",      32'(sent),         32'd20);
        chk("t3_rx",        32'(rx_cnt - rx0), 32'd20);
        chk("t3_count_le4", 32'(maxc <= 4),    32'd1);

        // ---------------- 4: lane mask ----------------
        in_valid = 1'b1; in_data = {8'hAA, 8'hBB, 8'hCC}; in_mask = 3'b010;
        tick();
        in_valid = 1'b0;
        chk("t4_data", 32'(out_data), 32'h00BB00);
        chk("t4_mask", 32'(out_mask), 32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_drained", 32'(count), 32'd0);

        // ---------------- 5: drop mode ----------------
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_ready", 32'(d_in_ready), 32'd1);
        in_valid = 1'b1; in_mask = 3'b000; in_data = {8'h09, 8'h08, 8'h07};
        repeat (3) tick();
        in_mask = 3'b111; in_data = {8'h01, 8'h02, 8'h03};
        tick();
        in_valid = 1'b0;
        chk("t5_count", 32'(d_count),    32'd1);
        chk("t5_drop3", 32'(d_drop_cnt), 32'd3);
        chk("t5_data",  32'(d_out_data), 32'h010203);
        in_valid = 1'b1; in_mask = 3'b000;
        repeat (300) tick();
        in_valid = 1'b0;
        chk("t5_drop_sat",   32'(d_drop_cnt), 32'd255);
        chk("t5_count_kept", 32'(d_count),    32'd1);
        chk("t5_nodrop",     32'(drop_cnt),   32'd0);
        chk("t5_zero_store", 32'(count),      32'd4);

        // Plain flush: contents cleared, drop counter kept.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_count",  32'(count),       32'd0);
        chk("fl_ready",  32'(in_ready),    32'd1);
        chk("fl_af",     32'(almost_full), 32'd0);
        chk("fl_dvalid", 32'(d_out_valid), 32'd0);
        chk("fl_drop",   32'(d_drop_cnt),  32'd255);

        // ---------------- 6: flush collision and async reset ----------------
        in_valid = 1'b1; in_mask = 3'b111;
        for (int k = 0; k < 3; k++) begin
            in_data = {3{8'(8'hE0 + k)}};
            tick();
        end
        chk("t6_count3", 32'(count),       32'd3);
        chk("t6_af",     32'(almost_full), 32'd1);
        in_data = {3{8'hEE}};
        flush = 1'b1; out_ready = 1'b1;
        rx0 = rx_cnt;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6_count0", 32'(count),       32'd0);
        chk("t6_valid0", 32'(out_valid),   32'd0);
        chk("t6_af0",    32'(almost_full), 32'd0);
        chk("t6_ready",  32'(in_ready),    32'd1);
        repeat (3) tick();
        chk("t6_none_seen", 32'(rx_cnt - rx0), 32'd0);
        out_ready = 1'b0;

        in_valid = 1'b1; in_data = {8'h5A, 8'hA5, 8'h3C};
        repeat (2) tick();
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(count),       32'd0);
        chk("ar_valid", 32'(out_valid),   32'd0);
        chk("ar_data",  32'(out_data),    32'd0);
        chk("ar_mask",  32'(out_mask),    32'd0);
        chk("ar_ready", 32'(in_ready),    32'd0);
        chk("ar_af",    32'(almost_full), 32'd0);
        chk("ar_drop",  32'(d_drop_cnt),  32'd0);
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("ar_after_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
